// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with debounce and a level valid/ack handshake.
// Define KEYPAD_REPEAT_EN to auto-repeat a held key (first after 32 ticks, then every 8).
//
// state    | meaning
// SCAN     | rotating the low row each tick, looking for a single-key column pattern
// DEBOUNCE | row held, counting consecutive ticks that agree with the latched pattern
// PRESSED  | key accepted, row held until DEBOUNCE_CNT consecutive disagreeing ticks
module keypad_scan #(
   parameter int SCAN_DIV     = 200000,
   parameter int DEBOUNCE_CNT = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [3:0] row,
   input  logic [3:0] col,
   output logic [3:0] key_code,
   output logic       key_valid,
   input  logic       key_ack,
   output logic       key_held,
   output logic       overrun
);
   localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DW = $clog2(DEBOUNCE_CNT + 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CNT);
   // nibble {r,c} holds the hex code of row r, column c
   localparam logic [63:0] KEY_TABLE = 64'hDF0E_C987_B654_A321;

   typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED} state_t;

   state_t        state_q, state_d;
   logic [3:0]    col_meta_q, col_meta_d;
   logic [3:0]    col_s_q, col_s_d;
   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic [3:0]    row_q, row_d;
   logic [3:0]    lat_col_q, lat_col_d;
   logic [3:0]    lat_rc_q, lat_rc_d;
   logic [DW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] rel_cnt_q, rel_cnt_d;
   logic [3:0]    key_code_q, key_code_d;
   logic          key_valid_q, key_valid_d;
   logic          key_held_q, key_held_d;
   logic          overrun_q, overrun_d;
`ifdef KEYPAD_REPEAT_EN
   localparam logic [5:0] RPT_FIRST  = 6'd32;
   localparam logic [5:0] RPT_PERIOD = 6'd8;
   logic [5:0]    rpt_cnt_q, rpt_cnt_d;
`endif

   logic       tick;
   logic [1:0] row_idx;
   logic [1:0] col_idx;
   logic       pat_valid;
   logic [3:0] row_rot;
   logic       accept;
   logic [3:0] accept_rc;

   assign tick    = (tick_cnt_q == TICK_LAST);
   assign row_rot = {row_q[2:0], row_q[3]};

   always_comb begin
      row_idx = 2'd3;
      case (row_q)
         4'b1110: row_idx = 2'd0;
         4'b1101: row_idx = 2'd1;
         4'b1011: row_idx = 2'd2;
         default: row_idx = 2'd3;
      endcase
      col_idx   = 2'd0;
      pat_valid = 1'b1;
      case (col_s_q)
         4'b1110: col_idx = 2'd0;
         4'b1101: col_idx = 2'd1;
         4'b1011: col_idx = 2'd2;
         4'b0111: col_idx = 2'd3;
         default: pat_valid = 1'b0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      col_meta_d  = col;
      col_s_d     = col_meta_q;
      tick_cnt_d  = tick ? '0 : tick_cnt_q + 1'b1;
      row_d       = row_q;
      lat_col_d   = lat_col_q;
      lat_rc_d    = lat_rc_q;
      cnt_d       = cnt_q;
      rel_cnt_d   = rel_cnt_q;
      key_code_d  = key_code_q;
      key_valid_d = key_valid_q;
      key_held_d  = key_held_q;
      overrun_d   = overrun_q;
      accept      = 1'b0;
      accept_rc   = lat_rc_q;
`ifdef KEYPAD_REPEAT_EN
      rpt_cnt_d   = rpt_cnt_q;
`endif
      if (tick) begin
         case (state_q)
            SCAN: begin
               if (pat_valid) begin
                  lat_col_d = col_s_q;
                  lat_rc_d  = {row_idx, col_idx};
                  cnt_d     = DW'(1);
                  if (DEBOUNCE_CNT == 1) begin
                     accept    = 1'b1;
                     accept_rc = {row_idx, col_idx};
                     rel_cnt_d = '0;
                     state_d   = PRESSED;
                  end else begin
                     state_d = DEBOUNCE;
                  end
               end else begin
                  row_d = row_rot;
               end
            end
            DEBOUNCE: begin
               if (col_s_q == lat_col_q) begin
                  cnt_d = cnt_q + 1'b1;
                  if (cnt_d == DB_LAST) begin
                     accept    = 1'b1;
                     rel_cnt_d = '0;
                     state_d   = PRESSED;
                  end
               end else begin
                  cnt_d   = '0;
                  row_d   = row_rot;
                  state_d = SCAN;
               end
            end
            PRESSED: begin
               rel_cnt_d = (col_s_q == lat_col_q) ? '0 : rel_cnt_q + 1'b1;
               if (rel_cnt_d == DB_LAST) begin
                  rel_cnt_d  = '0;
                  cnt_d      = '0;
                  key_held_d = 1'b0;
                  row_d      = row_rot;
                  state_d    = SCAN;
               end
`ifdef KEYPAD_REPEAT_EN
               else begin
                  // reload so the next repeat lands RPT_PERIOD ticks later
                  rpt_cnt_d = rpt_cnt_q + 1'b1;
                  if (rpt_cnt_d == RPT_FIRST) begin
                     accept    = 1'b1;
                     rpt_cnt_d = RPT_FIRST - RPT_PERIOD;
                  end
               end
`endif
            end
            default: state_d = SCAN;
         endcase
      end
`ifdef KEYPAD_REPEAT_EN
      if (state_q != PRESSED) rpt_cnt_d = '0;
`endif
      if (key_ack) begin
         key_valid_d = 1'b0;
         overrun_d   = 1'b0;
      end
      // acceptance overrides a same-cycle ack; overrun reflects valid before the ack
      if (accept) begin
         key_code_d  = KEY_TABLE[{accept_rc, 2'b00} +: 4];
         key_valid_d = 1'b1;
         key_held_d  = 1'b1;
         overrun_d   = key_valid_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= SCAN;
         col_meta_q  <= 4'hF;
         col_s_q     <= 4'hF;
         tick_cnt_q  <= '0;
         row_q       <= 4'b1110;
         lat_col_q   <= 4'hF;
         lat_rc_q    <= '0;
         cnt_q       <= '0;
         rel_cnt_q   <= '0;
         key_code_q  <= '0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
         overrun_q   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
         rpt_cnt_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         col_meta_q  <= col_meta_d;
         col_s_q     <= col_s_d;
         tick_cnt_q  <= tick_cnt_d;
         row_q       <= row_d;
         lat_col_q   <= lat_col_d;
         lat_rc_q    <= lat_rc_d;
         cnt_q       <= cnt_d;
         rel_cnt_q   <= rel_cnt_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         key_held_q  <= key_held_d;
         overrun_q   <= overrun_d;
`ifdef KEYPAD_REPEAT_EN
         rpt_cnt_q   <= rpt_cnt_d;
`endif
      end
   end

   assign row       = row_q;
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign key_held  = key_held_q;
   assign overrun   = overrun_q;
endmodule
